rs_dispatch_sched: RTL

RS_DISPATCH_SCHED -- requirements
Module: rs_dispatch_sched

---
 rtl/rs_dispatch_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rs_dispatch_sched.sv
// rs_dispatch_sched: oldest-first reservation-station dispatch scheduler.
// Define SCHED_AGE_WRAP_EN for wrap-safe age arbitration against cur_cnt_i.
module rs_dispatch_sched #(
    parameter int N_RS    = 4,
    parameter int STAMP_W = 10,
    parameter int WD_MAX  = 255,
    localparam int SEL_W  = (N_RS > 1) ? $clog2(N_RS) : 1,
    localparam int WD_W   = $clog2(WD_MAX + 1)
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic [N_RS-1:0]         rdy_i,
    input  logic [N_RS*STAMP_W-1:0] stamp_i,
    input  logic [STAMP_W-1:0]      cur_cnt_i,
    input  logic                    fu_busy_i,
    input  logic                    fu_done_i,
    input  logic                    flush_i,
    output logic                    start_o,
    output logic [SEL_W-1:0]        sel_o,
    output logic [N_RS-1:0]         gnt_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic [15:0]             issue_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_RS-1:0]  gnt_q, gnt_d;
    logic             err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic [SEL_W-1:0]   win_idx;
    logic [STAMP_W-1:0] best_key;
    logic [STAMP_W-1:0] key;
    logic               found;

`ifndef SCHED_AGE_WRAP_EN
    logic unused_cur;
    assign unused_cur = ^cur_cnt_i;
`endif

    // Strict compare keeps the lowest index on an age tie.
    always_comb begin
        win_idx  = '0;
        best_key = '0;
        key      = '0;
        found    = 1'b0;
        for (int k = 0; k < N_RS; k++) begin
`ifdef SCHED_AGE_WRAP_EN
            key = cur_cnt_i - stamp_i[k*STAMP_W +: STAMP_W];
            if (rdy_i[k] && (!found || key > best_key)) begin
`else
            key = stamp_i[k*STAMP_W +: STAMP_W];
            if (rdy_i[k] && (!found || key < best_key)) begin
`endif
                found    = 1'b1;
                best_key = key;
                win_idx  = SEL_W'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        start_o = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            gnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|rdy_i && !fu_busy_i) begin
                        state_d = ISSUE;
                        sel_d   = win_idx;
                        gnt_d   = N_RS'(1) << win_idx;
                    end
                end
                ISSUE: begin
                    start_o = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    wd_d    = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (fu_done_i) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                        if (wd_d == WD_W'(WD_MAX)) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                            gnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
        end
    end

    assign sel_o       = sel_q;
    assign gnt_o       = gnt_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;
    assign issue_cnt_o = cnt_q;

endmodule
